// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues word reads to
// instruction memory over a req/ack handshake, and buffers returned words in
// a small queue that decode drains through a valid/ready handshake.
// A redirect flushes the queue and any in-flight response.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; waits for a free queue slot
// REQ   | request to imem_addr outstanding; the response will be queued
// DROP  | request outstanding but wrong-path; the response is discarded
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   addr_q, addr_nxt;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_after_pop;
    logic          pop, push;
    logic [31:0]   target_aligned;
    logic [1:0]    unused_tgt_lsbs;

    assign unused_tgt_lsbs = redirect_target[1:0];
    assign target_aligned  = {redirect_target[31:2], 2'b00};

    // A redirect cancels the pop: the whole queue is discarded anyway.
    assign instr_valid     = (count != '0);
    assign pop             = instr_valid && instr_ready && !redirect_valid;
    assign count_after_pop = count - CW'(pop);

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = addr_q;
    assign instr     = instr_valid ? q_instr[rd_ptr] : 32'h0;
    assign instr_pc  = instr_valid ? q_pc[rd_ptr]    : 32'h0;

    // Next-state, next fetch PC, request address and push decision.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = addr_q;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = target_aligned;
                end else if (count_after_pop < QD) begin
                    state_nxt = REQ;
                    addr_nxt  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = target_aligned;
                    state_nxt    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    // Only keep requesting if the next word already has a slot.
                    if ((count_after_pop + CW'(1)) < QD) begin
                        addr_nxt = fetch_pc + 32'd4;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = target_aligned;
                end
                if (imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, fetch PC and latched request address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            addr_q   <= addr_nxt;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_after_pop + CW'(push);
        end
    end

    // Queue storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_pc[wr_ptr]    <= addr_q;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a zero-wait (auto) or hand-driven memory.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        mem_auto;
    logic        ack_man;
    int          n_checks;
    int          n_errors;

    localparam logic [31:0] XK = 32'hA5A5_0000;

    instr_fetch #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // Memory model: zero-wait ack follows the request, or a hand-driven ack.
    assign imem_ack   = mem_auto ? imem_req : ack_man;
    assign imem_rdata = imem_addr ^ XK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (first cycle with reset low).
    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        ack_man = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mem_auto = 1'b1;
        instr_ready = 1'b1;
        reset = 1'b1;
        redirect_valid = 1'b0;
        ack_man = 1'b0;
        step();
        step();
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        n_checks++; if (instr_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        reset = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL cycle1_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL cycle2_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL cycle2_addr got %h exp 0", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL cycle2_valid got %b exp 0", instr_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        mem_auto = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            epc = 32'(4 * i);
            n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, instr_valid); end
            n_checks++; if (instr_pc !== epc) begin n_errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, instr_pc, epc); end
            n_checks++; if (instr !== (epc ^ XK)) begin n_errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr, epc ^ XK); end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] epc;
        mem_auto = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req); end
            n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, instr_valid); end
            n_checks++; if (instr_pc !== 32'h0) begin n_errors++; $display("FAIL stall_pc[%0d] got %h exp 0", i, instr_pc); end
            n_checks++; if (instr !== XK) begin n_errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, instr, XK); end
            step();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            epc = 32'(4 * i);
            n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL release_valid[%0d] got %b exp 1", i, instr_valid); end
            n_checks++; if (instr_pc !== epc) begin n_errors++; $display("FAIL release_pc[%0d] got %h exp %h", i, instr_pc, epc); end
            step();
        end
    endtask

    task automatic test_redirect_full();
        mem_auto = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL rfull_prefill_valid got %b exp 1", instr_valid); end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rfull_flush_valid got %b exp 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rfull_flush_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rfull_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h40) begin n_errors++; $display("FAIL rfull_addr got %h exp 40", imem_addr); end
        step();
        n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL rfull_valid got %b exp 1", instr_valid); end
        n_checks++; if (instr_pc !== 32'h40) begin n_errors++; $display("FAIL rfull_pc got %h exp 40", instr_pc); end
        n_checks++; if (instr !== (32'h40 ^ XK)) begin n_errors++; $display("FAIL rfull_instr got %h exp %h", instr, 32'h40 ^ XK); end
    endtask

    task automatic test_latency_redirect();
        mem_auto = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        step();
        ack_man = 1'b1;
        step();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        n_checks++; if (imem_addr !== 32'h8) begin n_errors++; $display("FAIL lat_addr8 got %h exp 8", imem_addr); end
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h103;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL lat_drop_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h8) begin n_errors++; $display("FAIL lat_drop_addr got %h exp 8", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL lat_drop_valid got %b exp 0", instr_valid); end
        step();
        ack_man = 1'b1;
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL lat_ack_valid got %b exp 0", instr_valid); end
        step();
        ack_man = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL lat_stale_valid got %b pc %h exp 0", instr_valid, instr_pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL lat_idle_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL lat_new_req got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h100) begin n_errors++; $display("FAIL lat_new_addr got %h exp 100", imem_addr); end
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        n_checks++; if (instr_pc !== 32'h100 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL lat_first_pc got %h valid %b exp 100 valid 1", instr_pc, instr_valid); end
        n_checks++; if (instr !== (32'h100 ^ XK)) begin n_errors++; $display("FAIL lat_first_instr got %h exp %h", instr, 32'h100 ^ XK); end
    endtask

    task automatic test_redirect_ack();
        mem_auto = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        step();
        ack_man = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        step();
        ack_man = 1'b0;
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rack_req got %b exp 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rack_valid got %b exp 0", instr_valid); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rack_req2 got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h80) begin n_errors++; $display("FAIL rack_addr got %h exp 80", imem_addr); end
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin n_errors++; $display("FAIL rack_pc got %h valid %b exp 80 valid 1", instr_pc, instr_valid); end
    endtask

    task automatic test_reset_midflight();
        mem_auto = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        step();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        step();
        n_checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_errors++; $display("FAIL mid_pending got addr %h req %b exp 4 1", imem_addr, imem_req); end
        reset = 1'b1;
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid got %b exp 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL mid_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL mid_addr got %h exp 0", imem_addr); end
        reset = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL mid_restart got req %b addr %h exp 1 0", imem_req, imem_addr); end
        ack_man = 1'b1;
        instr_ready = 1'b1;
        step();
        ack_man = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_errors++; $display("FAIL mid_first got valid %b pc %h exp 1 0", instr_valid, instr_pc); end
        n_checks++; if (instr !== XK) begin n_errors++; $display("FAIL mid_instr got %h exp %h", instr, XK); end
    endtask

    task automatic test_wrap();
        mem_auto = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL wrap_idle_req got %b exp 0", imem_req); end
        step();
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        step();
        n_checks++; if (instr_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_pc got %h exp fffffffc", instr_pc); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_next got req %b addr %h exp 1 0", imem_req, imem_addr); end
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_pc0 got valid %b pc %h exp 1 0", instr_valid, instr_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        mem_auto = 1'b1;
        ack_man = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_latency_redirect();
        test_redirect_ack();
        test_reset_midflight();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the MIPS CPU. It owns the fetch PC, issues word reads to instruction memory over a request/ack handshake, and buffers returned words in a small FIFO. It hands them to decode through a valid/ready handshake. Decode/execute redirects it on a resolved BEQ/J, which flushes all wrong-path work.

## Interface
- `RESET_PC`, default `32'h0`: fetch PC loaded by reset. Must be word-aligned.
- `QDEPTH`, default `2`: instruction queue entries. Power of two, ≥2.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 32: byte address of the request. Word-aligned. Stable while `imem_req` is high.
- `imem_ack` in 1: one-cycle pulse, `imem_rdata` valid. May arrive in the same cycle as the request or any later cycle.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: control-flow change this cycle.
- `redirect_target` in 32: new PC. Bits [1:0] are ignored and treated as 0.
- `instr_valid` out 1: queue head is valid.
- `instr` out 32: queue head instruction.
- `instr_pc` out 32: byte address of `instr`.
- `instr_ready` in 1: decode accepts the head this cycle.

## Operation
- **State**
  - `fetch_pc`: next address to request.
  - Queue of {pc, instr} pairs.
  - `count`: 0..QDEPTH.
  - FSM with states IDLE, REQ, DROP.
- **Reset** (synchronous; overrides everything, including a mid-flight ack)
  - `fetch_pc`=RESET_PC, queue empty, state=IDLE.
  - `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- **Outputs**
  - `imem_req` = (state==REQ || state==DROP).
  - `imem_addr` = address latched on entry to REQ.
  - `instr_valid` = (count>0).
  - `instr`/`instr_pc` = queue head.
- **Pop**: occurs when `instr_valid && instr_ready`.
- **FSM transitions (no redirect)**
  - IDLE → REQ when `count_after_pop < QDEPTH`. Latch `imem_addr`=`fetch_pc`.
  - REQ, no ack: stay. Address held.
  - REQ with `imem_ack`:
    - Push {imem_addr, imem_rdata}.
    - `fetch_pc` += 4, wrapping at 2^32.
    - If `count - pop + 1 < QDEPTH`: stay REQ and latch the new `fetch_pc` as `imem_addr`. Otherwise go to IDLE.
  - Slot reservation: a request is issued only when a free slot exists. A push therefore never overflows, including when push and pop happen in the same cycle.
- **Redirect** (priority over push and pop)
  - Queue flushed. No pop is counted that cycle.
  - `fetch_pc` = {redirect_target[31:2], 2'b00}.
  - IDLE → IDLE.
  - REQ with no ack that cycle → DROP. The outstanding response must be discarded.
  - REQ with ack the same cycle → data discarded, → IDLE.
  - DROP: stay DROP; `fetch_pc` updated.
- **DROP**
  - `imem_req` stays high with the old address until ack.
  - On ack: discard data, → IDLE. No push and no `fetch_pc` change.
- **Empty queue**: `instr_valid`=0. `instr_ready` is ignored.

## Timing
- `imem_req` first rises in the 2nd cycle after `reset` deasserts: cycle 1 is IDLE, cycle 2 is REQ.
- Ack sampled at edge k → `instr_valid` high in cycle k+1.
- With zero-wait memory and `instr_ready`=1 throughout:
  - Sustained throughput is one instruction per cycle.
  - Consecutive `instr_pc` values are +4 apart.
- After redirect at edge k:
  - `instr_valid`=0 from cycle k+1.
  - Next request to the target is in cycle k+2, plus any DROP wait.
  - First target instruction is no earlier than cycle k+3.
- Queue full and `instr_ready`=0: `imem_req`=0. Held outputs do not change.

## Test plan
- Reset, zero-wait memory returning `rdata`=addr^32'hA5A5_0000, `instr_ready`=1 → `instr_pc` sequence 0,4,8,C on consecutive cycles from cycle 3, with matching `instr`.
- `instr_ready`=0 for 5 cycles after the first fetch → `count` reaches 2, `imem_req`=0, head stays pc 0. Releasing ready yields pcs 0,4,8 with no gap or duplicate.
- Redirect to 32'h40 while the queue holds 2 entries → `instr_valid`=0 next cycle. Next `imem_addr`=40, first delivered `instr_pc`=40.
- 3-cycle memory latency, redirect to 32'h103 in the 2nd wait cycle → stale data at 8 discarded, next `imem_addr`=100. No instruction with pc 8 is delivered.
- Redirect on the same edge as ack → acked word dropped, state IDLE, then request to target.
- Reset asserted while a request is outstanding, ack on the same edge → queue empty, `fetch_pc`=RESET_PC, no push. The fetch sequence restarts at 0.
- `fetch_pc` 32'hFFFF_FFFC → next request address 32'h0.
